// File: rtl/project_mux_pkg.sv
// Shared types and constants for the user-project selector: FSM states,
// config register bit positions and the drain-timeout fill word.
package project_mux_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int SRC_BIT    = 8;
  localparam int BUSY_BIT   = 16;
  localparam int ERR_BIT    = 17;
  localparam int ACTIVE_LSB = 24;

  localparam logic [31:0] DRAIN_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser on the raw select pins followed by a stability filter:
// a value is accepted once it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module sel_debounce #(
  parameter int CFG_BITS        = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_BITS-1:0] raw,
  output logic [CFG_BITS-1:0] stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CFG_BITS-1:0] sync1, sync2, cand;
  logic [CW-1:0]       cnt;

  // The cycle a new value first appears counts as cycle one, so acceptance
  // happens when the counter reaches DEBOUNCE_CYCLES-2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 2)) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/project_mux_ctrl.sv
// Runtime selector for several user projects in one user area: drains an open
// bus cycle, holds every project in reset, then releases only the new one.
module project_mux_ctrl
  import project_mux_pkg::*;
#(
  parameter int          USER_PROJECTS   = 4,
  parameter int          CFG_BITS        = (USER_PROJECTS > 2) ? $clog2(USER_PROJECTS) : 1,
  parameter int          IO_BITS         = 38 - CFG_BITS,
  parameter logic [31:0] CFG_ADDRESS     = 32'h300F_FFFC,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          RESET_CYCLES    = 8,
  parameter int          DRAIN_TIMEOUT   = 64
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              wbs_stb_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_we_i,
  input  logic [3:0]                        wbs_sel_i,
  input  logic [31:0]                       wbs_adr_i,
  input  logic [31:0]                       wbs_dat_i,
  output logic                              wbs_ack_o,
  output logic [31:0]                       wbs_dat_o,
  input  logic [CFG_BITS-1:0]               pin_sel_i,
  output logic [USER_PROJECTS-1:0]          proj_wbs_stb_o,
  input  logic [USER_PROJECTS-1:0]          proj_wbs_ack_i,
  input  logic [32*USER_PROJECTS-1:0]       proj_wbs_dat_i,
  input  logic [IO_BITS*USER_PROJECTS-1:0]  proj_io_out_i,
  input  logic [IO_BITS*USER_PROJECTS-1:0]  proj_io_oeb_i,
  input  logic [3*USER_PROJECTS-1:0]        proj_irq_i,
  output logic [IO_BITS-1:0]                io_out_o,
  output logic [IO_BITS-1:0]                io_oeb_o,
  output logic [2:0]                        user_irq_o,
  output logic [USER_PROJECTS-1:0]          proj_clk_en_o,
  output logic [USER_PROJECTS-1:0]          proj_rst_o,
  output logic [CFG_BITS-1:0]               active_sel_o
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  state_t                   state, state_nx;
  logic [CFG_BITS-1:0]      active, pending, reg_sel, pin_stable, target;
  logic                     src, err, cfg_ack, to_ack;
  logic [31:0]              cfg_rdata, cfg_word;
  logic [HW-1:0]            hold_cnt;
  logic [DW-1:0]            drain_cnt;
  logic [USER_PROJECTS-1:0] act_onehot;
  logic                     is_cfg, cfg_hit, cfg_wr, fwd_req, fwd_en, act_ack;
  logic                     target_ok, switch_req, drain_timeout, drain_expire;
  logic                     unused_ok;

  sel_debounce #(
    .CFG_BITS        (CFG_BITS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .raw    (pin_sel_i),
    .stable (pin_stable)
  );

  assign is_cfg        = (wbs_adr_i[31:2] == CFG_ADDRESS[31:2]);
  assign cfg_hit       = wbs_cyc_i & wbs_stb_i & is_cfg;
  assign cfg_wr        = cfg_hit & wbs_we_i & ~cfg_ack;
  assign fwd_req       = wbs_cyc_i & wbs_stb_i & ~is_cfg;
  assign fwd_en        = (state == RUN) || (state == DRAIN);
  assign act_ack       = proj_wbs_ack_i[active];
  assign act_onehot    = USER_PROJECTS'(1) << active;
  assign target        = src ? reg_sel : pin_stable;
  assign target_ok     = int'(target) < USER_PROJECTS;
  assign switch_req    = (state == RUN) && (target != active) && target_ok;
  assign drain_timeout = (drain_cnt == DW'(DRAIN_TIMEOUT - 1));
  assign drain_expire  = (state == DRAIN) && fwd_req && !act_ack && drain_timeout;
  assign unused_ok     = &{1'b0, wbs_sel_i[3], wbs_dat_i};

  // Valid/ready: the host holds cyc&stb until it samples wbs_ack_o high; a
  // project request counts as open from that point until its ack returns.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= HOLD;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:    if (switch_req) state_nx = (fwd_req && !act_ack) ? DRAIN : SWITCH;
      DRAIN:  if (act_ack || !fwd_req || drain_timeout) state_nx = SWITCH;
      SWITCH: state_nx = HOLD;
      HOLD:   if (hold_cnt <= HW'(1)) state_nx = RUN;
      default: state_nx = HOLD;
    endcase
  end

  always_comb begin
    cfg_word                      = '0;
    cfg_word[CFG_BITS-1:0]        = reg_sel;
    cfg_word[SRC_BIT]             = src;
    cfg_word[BUSY_BIT]            = (state != RUN);
    cfg_word[ERR_BIT]             = err;
    cfg_word[ACTIVE_LSB +: 8]     = 8'(active);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      active        <= '0;
      pending       <= '0;
      hold_cnt      <= HW'(RESET_CYCLES);
      drain_cnt     <= '0;
      src           <= 1'b0;
      reg_sel       <= '0;
      err           <= 1'b0;
      cfg_ack       <= 1'b0;
      cfg_rdata     <= '0;
      to_ack        <= 1'b0;
      proj_rst_o    <= '1;
      proj_clk_en_o <= '0;
    end else begin
      cfg_ack   <= cfg_hit & ~cfg_ack;
      cfg_rdata <= cfg_word;
      to_ack    <= drain_expire;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      // Target is frozen at the decision point; later changes wait for RUN.
      if (switch_req) pending <= target;
      if (state == SWITCH) begin
        active   <= pending;
        hold_cnt <= HW'(RESET_CYCLES);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (cfg_wr && wbs_sel_i[0]) reg_sel <= wbs_dat_i[CFG_BITS-1:0];
      if (cfg_wr && wbs_sel_i[1]) src <= wbs_dat_i[SRC_BIT];
      if (drain_expire || (state == RUN && !target_ok)) err <= 1'b1;
      else if (cfg_wr && wbs_sel_i[2] && wbs_dat_i[ERR_BIT]) err <= 1'b0;
      // Only HOLD enters RUN, and active is already final by then.
      proj_clk_en_o <= (state_nx == RUN) ? act_onehot : '0;
      proj_rst_o    <= (state_nx == RUN) ? ~act_onehot : '1;
    end
  end

  always_comb begin
    proj_wbs_stb_o = (fwd_en && fwd_req) ? act_onehot : '0;
    wbs_ack_o      = cfg_ack | to_ack | (fwd_en & fwd_req & act_ack);
    if (cfg_ack)     wbs_dat_o = cfg_rdata;
    else if (to_ack) wbs_dat_o = DRAIN_FILL;
    else             wbs_dat_o = proj_wbs_dat_i[32*int'(active) +: 32];
    if (state == RUN) begin
      io_out_o   = proj_io_out_i[IO_BITS*int'(active) +: IO_BITS];
      io_oeb_o   = proj_io_oeb_i[IO_BITS*int'(active) +: IO_BITS];
      user_irq_o = proj_irq_i[3*int'(active) +: 3];
    end else begin
      io_out_o   = '0;
      io_oeb_o   = '1;
      user_irq_o = '0;
    end
  end

  assign active_sel_o = active;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed bench for project_mux_ctrl: a four-project instance for the main
// flows and a three-project instance for the out-of-range select case.
module tb_project_mux_ctrl;

  localparam int          NP   = 4;
  localparam int          CB   = 2;
  localparam int          IOB  = 36;
  localparam logic [31:0] CFGA = 32'h300F_FFFC;
  localparam logic [31:0] PADR = 32'h3000_0010;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 clk = ~clk;

  logic              stb = 0, cyc = 0, we = 0;
  logic [3:0]        sel = 0;
  logic [31:0]       adr = 0, dat = 0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [CB-1:0]     pin_sel = 0;
  logic [NP-1:0]     proj_stb, proj_ack = 0, mute = 0;
  logic [32*NP-1:0]  proj_dat;
  logic [IOB*NP-1:0] proj_io_out, proj_io_oeb;
  logic [3*NP-1:0]   proj_irq;
  logic [IOB-1:0]    io_out_o, io_oeb_o;
  logic [2:0]        user_irq_o;
  logic [NP-1:0]     proj_clk_en_o, proj_rst_o;
  logic [CB-1:0]     active_sel_o;

  logic              stb3 = 0, cyc3 = 0, we3 = 0;
  logic [3:0]        sel3 = 0;
  logic [31:0]       adr3 = 0, dat3 = 0;
  logic              ack3;
  logic [31:0]       dat3_o;
  logic [2:0]        stb3_o, en3_o, rst3_o;
  logic [IOB-1:0]    io3_out, io3_oeb;
  logic [2:0]        irq3;
  logic [CB-1:0]     act3;

  logic [31:0] exp_q[$];
  logic [31:0] exp3_q[$];
  int compared = 0;
  int mismatched = 0;

  project_mux_ctrl #(.USER_PROJECTS(NP)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .pin_sel_i(pin_sel), .proj_wbs_stb_o(proj_stb), .proj_wbs_ack_i(proj_ack),
    .proj_wbs_dat_i(proj_dat), .proj_io_out_i(proj_io_out), .proj_io_oeb_i(proj_io_oeb),
    .proj_irq_i(proj_irq), .io_out_o(io_out_o), .io_oeb_o(io_oeb_o),
    .user_irq_o(user_irq_o), .proj_clk_en_o(proj_clk_en_o), .proj_rst_o(proj_rst_o),
    .active_sel_o(active_sel_o)
  );

  project_mux_ctrl #(.USER_PROJECTS(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(stb3), .wbs_cyc_i(cyc3), .wbs_we_i(we3), .wbs_sel_i(sel3),
    .wbs_adr_i(adr3), .wbs_dat_i(dat3), .wbs_ack_o(ack3), .wbs_dat_o(dat3_o),
    .pin_sel_i(2'd0), .proj_wbs_stb_o(stb3_o), .proj_wbs_ack_i(3'd0),
    .proj_wbs_dat_i(96'd0), .proj_io_out_i({3*IOB{1'b0}}), .proj_io_oeb_i({3*IOB{1'b1}}),
    .proj_irq_i(9'd0), .io_out_o(io3_out), .io_oeb_o(io3_oeb),
    .user_irq_o(irq3), .proj_clk_en_o(en3_o), .proj_rst_o(rst3_o),
    .active_sel_o(act3)
  );

  function automatic logic [IOB-1:0] pat(input int i);
    logic [3:0] n;
    n = 4'(i + 1);
    return {9{n}};
  endfunction

  initial begin
    for (int i = 0; i < NP; i++) begin
      proj_dat[32*i +: 32]     = 32'hC0DE_0000 | 32'(i);
      proj_io_out[IOB*i +: IOB] = pat(i);
      proj_io_oeb[IOB*i +: IOB] = ~pat(i);
      proj_irq[3*i +: 3]        = 3'(i + 1);
    end
  end

  // Project responders: one-cycle registered ack, silenced per project by mute.
  always @(posedge clk) proj_ack <= proj_stb & ~proj_ack & ~mute;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!wb_rst_i && wbs_ack_o && !we) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd_unexpected: got %h, want no ack", wbs_dat_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (wbs_dat_o !== e) begin
          mismatched++;
          $display("FAIL rd_data: got %h, want %h", wbs_dat_o, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!wb_rst_i && ack3 && !we3) begin
      compared++;
      if (exp3_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd3_unexpected: got %h, want no ack", dat3_o);
      end else begin
        logic [31:0] e;
        e = exp3_q.pop_front();
        if (dat3_o !== e) begin
          mismatched++;
          $display("FAIL rd3_data: got %h, want %h", dat3_o, e);
        end
      end
    end
  end

  // Bus master: holds the request until ack is seen, drops it on the next edge.
  task automatic wb_xfer(input bit d3, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [3:0] s, input int budget,
                         output int lat);
    bit got;
    @(posedge clk); #1;
    if (d3) begin cyc3 = 1; stb3 = 1; we3 = w; sel3 = s; adr3 = a; dat3 = d; end
    else    begin cyc  = 1; stb  = 1; we  = w; sel  = s; adr  = a; dat  = d; end
    lat = 0;
    got = 0;
    while (!got && lat < budget) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = d3 ? ack3 : wbs_ack_o;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL wb_timeout: got no ack at %h, want ack within %0d cycles", a, budget);
      if (!w) begin
        if (d3) void'(exp3_q.pop_back());
        else    void'(exp_q.pop_back());
      end
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; cyc3 = 0; stb3 = 0; we3 = 0;
  endtask

  task automatic wait_rst(input logic [NP-1:0] val, input int budget, input string name);
    int n = 0;
    while (proj_rst_o !== val && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(proj_rst_o), 64'(val));
  endtask

  task automatic wait_active(input logic [CB-1:0] val, input int budget, input string name);
    int n = 0;
    while (active_sel_o !== val && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(active_sel_o), 64'(val));
  endtask

  initial begin
    int lat;
    int cnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_proj_rst", 64'(proj_rst_o), 64'hF);
    check("rst_clk_en", 64'(proj_clk_en_o), 64'h0);
    check("rst_ack", 64'(wbs_ack_o), 64'h0);
    check("rst_oeb", 64'(io_oeb_o), {28'h0, {IOB{1'b1}}});
    check("rst_io_irq", {io_out_o, user_irq_o}, 64'h0);
    @(posedge clk); #1;
    wb_rst_i = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (proj_rst_o == 4'b1111) cnt++;
      else break;
    end
    check("post_reset_hold_len", 64'(cnt), 64'd8);
    check("run0_rst", 64'(proj_rst_o), 64'b1110);
    check("run0_en", 64'(proj_clk_en_o), 64'b0001);
    check("run0_io", 64'(io_out_o), 64'(pat(0)));
    check("run0_irq", 64'(user_irq_o), 64'd1);
    exp_q.push_back(32'h0000_0000);
    wb_xfer(0, CFGA, 0, 0, 4'hF, 20, lat);
    check("cfg_rd_latency", 64'(lat), 64'd1);

    // Pin select 0 -> 2 with a one-cycle glitch to 3
    @(posedge clk); #1; pin_sel = 2;
    repeat (5) @(posedge clk);
    #1; pin_sel = 3;
    @(posedge clk); #1; pin_sel = 2;
    repeat (16) @(posedge clk);
    #1;
    check("glitch_no_early_switch", 64'(active_sel_o), 64'd0);
    wait_active(2, 60, "pin_switch_active");
    check("pin_switch_in_hold", 64'(proj_rst_o), 64'hF);
    check("hold_oeb", 64'(io_oeb_o), {28'h0, {IOB{1'b1}}});
    wait_rst(4'b1011, 20, "pin_switch_rst");
    check("run2_en", 64'(proj_clk_en_o), 64'b0100);
    check("run2_io", 64'(io_out_o), 64'(pat(2)));
    check("run2_irq", 64'(user_irq_o), 64'd3);

    // Register select: src=1, reg_sel=1
    wb_xfer(0, CFGA, 32'h0000_0101, 1, 4'b0011, 20, lat);
    check("cfg_wr_latency", 64'(lat), 64'd1);
    wait_rst(4'b1101, 30, "reg_switch_rst");
    exp_q.push_back(32'h0100_0101);
    wb_xfer(0, CFGA, 0, 0, 4'hF, 20, lat);

    // Drain timeout: pins to 1 (no switch), back to pin source, then a stuck read
    @(posedge clk); #1; pin_sel = 1;
    repeat (25) @(posedge clk);
    wb_xfer(0, CFGA, 32'h0000_0001, 1, 4'b0011, 20, lat);
    repeat (3) @(posedge clk);
    #1;
    check("pin_src_same_target", 64'(active_sel_o), 64'd1);
    mute[1] = 1;
    pin_sel = 2;
    exp_q.push_back(32'hDEAD_BEEF);
    wb_xfer(0, PADR, 0, 0, 4'hF, 200, lat);
    check("drain_waited_timeout", 64'(lat > 64), 64'd1);
    wait_rst(4'b1011, 30, "drain_switch_rst");
    exp_q.push_back(32'h0202_0001);
    wb_xfer(0, CFGA, 0, 0, 4'hF, 20, lat);
    wb_xfer(0, CFGA, 32'h0002_0000, 1, 4'b0100, 20, lat);
    exp_q.push_back(32'h0200_0001);
    wb_xfer(0, CFGA, 0, 0, 4'hF, 20, lat);
    mute[1] = 0;

    // Project read issued during the switch is stalled, then served by the new project
    wb_xfer(0, CFGA, 32'h0000_0103, 1, 4'b0011, 20, lat);
    exp_q.push_back(32'hC0DE_0003);
    wb_xfer(0, PADR, 0, 0, 4'hF, 40, lat);
    check("hold_read_stalled", 64'(lat > 2), 64'd1);
    check("run3_rst", 64'(proj_rst_o), 64'b0111);
    check("run3_en", 64'(proj_clk_en_o), 64'b1000);
    check("run3_io", 64'(io_out_o), 64'(pat(3)));
    check("run3_irq", 64'(user_irq_o), 64'd4);

    // Three-project instance: select 3 is out of range
    wb_xfer(1, CFGA, 32'h0000_0103, 1, 4'b0011, 20, lat);
    repeat (12) @(posedge clk);
    #1;
    check("u3_active_kept", 64'(act3), 64'd0);
    check("u3_rst_kept", 64'(rst3_o), 64'b110);
    exp3_q.push_back(32'h0002_0103);
    wb_xfer(1, CFGA, 0, 0, 4'hF, 20, lat);

    repeat (4) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp3_q_drained", 64'(exp3_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
